prog_loader: RTL
================

Name: prog_loader

Overview:
- Instruction store and serial program loader on the supply side of the PWM executor's fetch interface.
- Holds 2**PC_WIDTH instruction words.
- Answers the executor's program-counter fetches combinationally.
- Accepts new programs over a bit-serial configuration stream, one bit per accepted cycle.
- Gates fetches to NOP while a load is in progress, so the executor never sees a half-written program.

Parameters:
- INSTR_WIDTH, 6, bits per instruction word.
- PC_WIDTH, 4, program-counter width; the store holds DEPTH = 2**PC_WIDTH words.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- cfg_en_i  input  1  frame enable; held high for the whole load frame
- cfg_valid_i  input  1  cfg_bit_i is accepted this cycle
- cfg_bit_i  input  1  serial data, MSB of each word first
- pc_i  input  PC_WIDTH  fetch address from the executor
- instr_o  output  INSTR_WIDTH  instruction at pc_i; all-zero (NOP) while busy
- busy_o  output  1  load frame in progress
- done_o  output  1  one-cycle pulse at frame end
- err_o  output  1  last frame had a partial word or an overflow; held until the next frame starts
- words_o  output  PC_WIDTH+1  words committed in the last frame, range 0..DEPTH

Behaviour:
- Reset (async assert, sync release):
  - all memory words = 0
  - state = StIdle; bit count, write pointer and shift register = 0
  - busy_o = 0, done_o = 0, err_o = 0, words_o = 0
- Fetch path:
  - instr_o = mem[pc_i] combinationally, zero latency, whenever state is StIdle.
  - In StLoad and StDone, instr_o = 0.
- StIdle:
  - cfg_en_i = 1 -> StLoad. Same edge clears bit count, write pointer, word counter and err_o.
  - cfg_valid_i in the entry cycle is ignored; the first bit is sampled the cycle after entry.
  - cfg_valid_i with cfg_en_i = 0 is always ignored.
- StLoad (busy_o = 1):
  - Each cycle with cfg_en_i = 1 and cfg_valid_i = 1: shift = {shift[INSTR_WIDTH-2:0], cfg_bit_i}, bit count + 1.
  - On the INSTR_WIDTH-th bit:
    - Write {shift[INSTR_WIDTH-2:0], cfg_bit_i} to mem[ptr] at that clock edge.
    - ptr + 1, word counter + 1, bit count = 0.
  - Overflow: when word counter = DEPTH, further completed words are discarded (no write, no wrap to address 0) and an overflow flag is set.
  - cfg_en_i = 0 -> StDone:
    - If bit count != 0, the partial word is dropped and a partial flag is set.
    - Any valid bit in this cycle is ignored.
- StDone (busy_o = 1, one cycle):
  - done_o = 1.
  - words_o = final word counter.
  - err_o = partial flag OR overflow flag.
  - -> StIdle unconditionally, even if cfg_en_i is already high again; a new frame needs cfg_en_i seen high in StIdle.
- Memory write port: only StLoad writes memory. Words beyond the committed count keep their old contents.
- Outputs busy_o, done_o, err_o and words_o are registered.
- The executor must not rely on fetches while busy_o = 1; it only sees NOPs. A frame of zero words is legal: done_o pulses, words_o = 0, err_o = 0.
- Async reset mid-frame aborts the load immediately and clears the whole memory.
- Any illegal state encoding -> StIdle.

Test Plan:
- Reset, then pc_i = 0..15 -> instr_o = 0 for every address; busy_o = 0, done_o = 0.
- Frame of 2 words 6'b101011, 6'b000111 (12 valid cycles, MSB first), then cfg_en_i low:
  - done_o pulses exactly once, 1 cycle after cfg_en_i falls.
  - words_o = 2, err_o = 0.
  - mem[0] = 6'h2B, mem[1] = 6'h07; all other words unchanged.
- Same frame with cfg_valid_i toggled every other cycle and random cfg_bit_i on invalid cycles -> identical memory contents and words_o = 2.
- Frame of 1 word plus 3 extra bits -> words_o = 1, err_o = 1, mem[1] unchanged. Next frame of 1 clean word -> err_o returns 0.
- Frame of 17 words -> mem[0..15] hold words 0..15, word 17 is not written, mem[0] keeps word 0, words_o = 16, err_o = 1.
- Hold pc_i = 0 throughout a load:
  - instr_o = 0 from the cycle after cfg_en_i rises through the StDone cycle.
  - The new mem[0] value appears on instr_o the cycle after done_o.
- Assert rst_n low after 3 words of a frame -> all outputs 0 and memory all-zero immediately, without a clock edge.

Source files
------------

// File: rtl/prog_loader.sv
// Instruction store plus bit-serial program loader. It sits on the supply side
// of the PWM executor's fetch interface.
//   clk, rst_n   : clock and asynchronous active-low reset
//   cfg_en_i     : load-frame enable, held high for the whole frame
//   cfg_valid_i  : cfg_bit_i is accepted this cycle
//   cfg_bit_i    : serial program data, MSB of each word first
//   pc_i         : fetch address from the executor
//   instr_o      : word at pc_i (combinational); NOP (zero) while a load is busy
//   busy_o       : load frame in progress
//   done_o       : one-cycle pulse at frame end
//   err_o        : last frame ended with a partial word or overflowed
//   words_o      : words committed in the last frame (0..DEPTH)
`timescale 1ns/1ps
module prog_loader #(
   parameter int unsigned INSTR_WIDTH = 6,
   parameter int unsigned PC_WIDTH    = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_en_i,
   input  logic                   cfg_valid_i,
   input  logic                   cfg_bit_i,
   input  logic [PC_WIDTH-1:0]    pc_i,
   output logic [INSTR_WIDTH-1:0] instr_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic [PC_WIDTH:0]      words_o
);

   localparam int unsigned DEPTH  = 2 ** PC_WIDTH;
   localparam int unsigned CNT_W  = (INSTR_WIDTH > 1) ? $clog2(INSTR_WIDTH) : 1;
   localparam int unsigned WCNT_W = PC_WIDTH + 1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StDone = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_next;

   logic [INSTR_WIDTH-1:0] mem [DEPTH];
   logic [INSTR_WIDTH-1:0] shift;
   logic [CNT_W-1:0]       bit_cnt;
   logic [PC_WIDTH-1:0]    ptr;
   logic [WCNT_W-1:0]      word_cnt;
   logic                   ovf;

   logic                   start_c;
   logic                   take_c;
   logic                   word_end_c;
   logic                   wr_en_c;
   logic                   finish_c;
   logic [INSTR_WIDTH-1:0] word_data_c;

   // Next-state and datapath strobes
   always_comb begin
      state_next  = state;
      start_c     = 1'b0;
      take_c      = 1'b0;
      word_end_c  = 1'b0;
      wr_en_c     = 1'b0;
      finish_c    = 1'b0;
      word_data_c = {shift[INSTR_WIDTH-2:0], cfg_bit_i};
      case (state)
         StIdle: begin
            if (cfg_en_i) begin
               state_next = StLoad;
               start_c    = 1'b1;
            end
         end
         StLoad: begin
            if (!cfg_en_i) begin
               state_next = StDone;
               finish_c   = 1'b1;
            end else if (cfg_valid_i) begin
               take_c = 1'b1;
               if (bit_cnt == CNT_W'(INSTR_WIDTH - 1)) begin
                  word_end_c = 1'b1;
                  // Once the store is full, completed words are dropped rather than wrapped
                  wr_en_c    = (word_cnt != WCNT_W'(DEPTH));
               end
            end
         end
         StDone: begin
            state_next = StIdle;
         end
         default: begin
            state_next = StIdle;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= StIdle;
      end else begin
         state <= state_next;
      end
   end

   // Shift register, counters, flags and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift    <= '0;
         bit_cnt  <= '0;
         ptr      <= '0;
         word_cnt <= '0;
         ovf      <= 1'b0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         err_o    <= 1'b0;
         words_o  <= '0;
      end else begin
         busy_o <= (state_next != StIdle);
         done_o <= (state_next == StDone);
         if (start_c) begin
            shift    <= '0;
            bit_cnt  <= '0;
            ptr      <= '0;
            word_cnt <= '0;
            ovf      <= 1'b0;
            err_o    <= 1'b0;
         end
         if (take_c) begin
            shift <= word_data_c;
            if (word_end_c) begin
               bit_cnt <= '0;
               if (wr_en_c) begin
                  ptr      <= ptr + PC_WIDTH'(1);
                  word_cnt <= word_cnt + WCNT_W'(1);
               end else begin
                  ovf <= 1'b1;
               end
            end else begin
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
         end
         // A nonzero bit count at frame end means a partial word was dropped
         if (finish_c) begin
            err_o   <= (bit_cnt != '0) | ovf;
            words_o <= word_cnt;
         end
      end
   end

   // Instruction store; reset clears every word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en_c) begin
         mem[ptr] <= word_data_c;
      end
   end

   // Fetches see NOP whenever a load is in flight
   assign instr_o = (state == StIdle) ? mem[pc_i] : '0;

endmodule
